// File: rtl/n64_joybus_rx_pkg.sv
// Shared Joybus definitions: command codes, decoder FSM states and the
// command-to-frame-length lookup.
package n64_pkg;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_e;

    // Frame length in bytes including the command byte; 0 marks an unknown command.
    function automatic logic [7:0] cmd_len(input logic [7:0] c);
        case (c)
            CMD_INFO, CMD_RESET, CMD_POLL: cmd_len = 8'd1;
            CMD_READ:                      cmd_len = 8'd3;
            CMD_WRITE:                     cmd_len = 8'd35;
            default:                       cmd_len = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/n64_joybus_rx_if.sv
// Bit-strobe input and decoded-frame outputs of the Joybus receiver.
interface n64_joybus_rx_if #(
    parameter int MAX_BYTES = 35
);
    localparam int IDX_W = $clog2(MAX_BYTES);

    logic             derived_signal;
    logic             derived_clk;
    logic [7:0]       cmd;
    logic             cmd_valid;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic [IDX_W-1:0] byte_index;
    logic             frame_done;
    logic             frame_error;
    logic             busy;

    // Upstream bit recovery plus the response logic that consumes the frames.
    modport master (
        output derived_signal, derived_clk,
        input  cmd, cmd_valid, byte_data, byte_valid, byte_index,
        input  frame_done, frame_error, busy
    );

    // The decoder itself.
    modport slave (
        input  derived_signal, derived_clk,
        output cmd, cmd_valid, byte_data, byte_valid, byte_index,
        output frame_done, frame_error, busy
    );
endinterface

// File: rtl/n64_joybus_rx_shifter.sv
// 8-bit MSB-first deserializer. byte_done and byte_out are combinational so
// the owner can register the completed byte on the same edge as the 8th bit.
module n64_bit_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       byte_done
);
    logic [6:0] sr;
    logic [2:0] cnt;

    assign byte_done = load && (cnt == 3'd7);
    assign byte_out  = {sr, bit_in};

    // Shift register and bit counter; counter wraps to 0 after each byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {sr[5:0], bit_in};
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: rtl/n64_joybus_rx.sv
// Joybus host-to-controller frame decoder: command identification, payload
// byte reporting, stop-bit check and idle-timeout handling.
module n64_joybus_rx
    import n64_pkg::*;
#(
    parameter int IDLE_CYCLES = 32,
    parameter int MAX_BYTES   = 35
) (
    input  logic          sample_clk,
    input  logic          reset,
    input  logic          enable,
    n64_joybus_rx_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_BYTES);
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

    rx_state_e        state, state_n;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       cmd_r, cmd_n, data_r, data_n, len_c;
    logic [IDX_W-1:0] idx_r, idx_n, last_r, last_n, idx_inc;
    logic             cv_r, cv_n, bv_r, bv_n, fd_r, fd_n, fe_r, fe_n;
    logic             acc, timeout, shift_ld, shift_clr, sh_done;
    logic [7:0]       sh_byte;

    // A strobe only counts while enabled; the idle timeout fires on the edge
    // where the counter would reach IDLE_CYCLES without a strobe.
    assign acc       = enable && bus.derived_clk;
    assign timeout   = enable && !bus.derived_clk && (idle_cnt == CNT_W'(IDLE_CYCLES - 1));
    assign shift_ld  = acc && (state == S_IDLE || state == S_CMD || state == S_PAYLOAD);
    assign shift_clr = timeout || (state == S_WAIT_IDLE);
    assign idx_inc   = idx_r + IDX_W'(1);

    n64_bit_shifter u_shift (
        .clk       (sample_clk),
        .rst_n     (reset),
        .load      (shift_ld),
        .clear     (shift_clr),
        .bit_in    (bus.derived_signal),
        .byte_out  (sh_byte),
        .byte_done (sh_done)
    );

    // Cycles since the last accepted strobe, saturating; frozen while disabled.
    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset)
            idle_cnt <= '0;
        else if (acc)
            idle_cnt <= '0;
        else if (enable && idle_cnt != CNT_W'(IDLE_CYCLES))
            idle_cnt <= idle_cnt + CNT_W'(1);
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_n = state;
        cmd_n   = cmd_r;
        data_n  = data_r;
        idx_n   = idx_r;
        last_n  = last_r;
        cv_n    = 1'b0;
        bv_n    = 1'b0;
        fd_n    = 1'b0;
        fe_n    = 1'b0;
        len_c   = 8'd0;
        case (state)
            S_IDLE: begin
                if (acc) state_n = S_CMD;
            end
            S_CMD: begin
                if (sh_done) begin
                    len_c  = cmd_len(sh_byte);
                    cmd_n  = sh_byte;
                    data_n = sh_byte;
                    idx_n  = '0;
                    cv_n   = 1'b1;
                    bv_n   = 1'b1;
                    if (len_c == 8'd0) begin
                        fe_n    = 1'b1;
                        state_n = S_WAIT_IDLE;
                    end else if (len_c == 8'd1) begin
                        state_n = S_STOP;
                    end else begin
                        last_n  = IDX_W'(len_c - 8'd1);
                        state_n = S_PAYLOAD;
                    end
                end else if (timeout) begin
                    fe_n    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (sh_done) begin
                    data_n = sh_byte;
                    idx_n  = idx_inc;
                    bv_n   = 1'b1;
                    if (idx_inc == last_r) state_n = S_STOP;
                end else if (timeout) begin
                    fe_n    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_STOP: begin
                if (acc) begin
                    fd_n    = bus.derived_signal;
                    fe_n    = !bus.derived_signal;
                    state_n = S_WAIT_IDLE;
                end else if (timeout) begin
                    fe_n    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (timeout) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cmd_r  <= '0;
            data_r <= '0;
            idx_r  <= '0;
            last_r <= '0;
            cv_r   <= 1'b0;
            bv_r   <= 1'b0;
            fd_r   <= 1'b0;
            fe_r   <= 1'b0;
        end else begin
            state  <= state_n;
            cmd_r  <= cmd_n;
            data_r <= data_n;
            idx_r  <= idx_n;
            last_r <= last_n;
            cv_r   <= cv_n;
            bv_r   <= bv_n;
            fd_r   <= fd_n;
            fe_r   <= fe_n;
        end
    end

    assign bus.cmd         = cmd_r;
    assign bus.cmd_valid   = cv_r;
    assign bus.byte_data   = data_r;
    assign bus.byte_valid  = bv_r;
    assign bus.byte_index  = idx_r;
    assign bus.frame_done  = fd_r;
    assign bus.frame_error = fe_r;
    assign bus.busy        = (state != S_IDLE);
endmodule

// File: doc/n64_joybus_rx.md
# n64_joybus_rx

Frame decoder for host-to-controller Joybus traffic. It sits directly downstream of `async_to_sync` and consumes that block's recovered bit (`derived_signal`) and bit strobe (`derived_clk`). It deserializes bits MSB-first into bytes and identifies the command byte. It knows the frame length for each command, checks the stop bit, and reports per-byte data plus frame completion or error to the fake-controller response logic.

## Interface

Parameters:
- `IDLE_CYCLES`, default 32: number of `sample_clk` cycles without a strobe that counts as a line-idle timeout. At 4 MHz this is 8 µs, about 2 bit times.
- `MAX_BYTES`, default 35: largest frame length in bytes, including the command byte. This sets the `byte_index` width as clog2(`MAX_BYTES`).

Ports:
- `sample_clk`, in, 1: the single clock, 4 MHz sample clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when low, strobes are ignored and the FSM holds its state.
- `derived_signal`, in, 1: recovered bit value. Valid only when `derived_clk` is high.
- `derived_clk`, in, 1: bit strobe, one `sample_clk` cycle high per decoded bit.
- `cmd`, out, 8: latched command byte. Holds its value until the next frame's command byte completes.
- `cmd_valid`, out, 1: one-cycle pulse when the command byte completes.
- `byte_data`, out, 8: most recently completed byte. This includes the command byte.
- `byte_valid`, out, 1: one-cycle pulse for each completed byte.
- `byte_index`, out, clog2(`MAX_BYTES`): position of `byte_data` in the frame. The command byte is index 0.
- `frame_done`, out, 1: one-cycle pulse when a valid stop bit is received.
- `frame_error`, out, 1: one-cycle pulse on a bad stop bit, a timeout in the middle of a frame, or an unknown command.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- FSM states: IDLE, CMD, PAYLOAD, STOP, WAIT_IDLE.
- IDLE:
  - The first accepted strobe is stored as bit 7 and moves the FSM to CMD.
- CMD:
  - Shift bits in MSB-first. On the 8th bit, load `cmd`.
  - Pulse `cmd_valid` and `byte_valid` with `byte_index`=0.
  - Set the expected byte count from the command:
    - 0x00 or 0xFF (info/reset): 1 byte. Next state is STOP.
    - 0x01 (poll): 1 byte. Next state is STOP.
    - 0x02 (read): 3 bytes. Next state is PAYLOAD.
    - 0x03 (write): 35 bytes. Next state is PAYLOAD.
    - Any other value: pulse `frame_error` in the same cycle as `cmd_valid`. Next state is WAIT_IDLE.
- PAYLOAD:
  - Shift bytes in the same way. Pulse `byte_valid` for each byte; `byte_index` increments from 1.
  - After the final expected byte, go to STOP.
- STOP:
  - The next strobe is the stop bit. A value of 1 pulses `frame_done`; a value of 0 pulses `frame_error`.
  - Either way, go to WAIT_IDLE.
- WAIT_IDLE:
  - Strobes are discarded; controller-reply echoes and trailing noise are never decoded.
  - Return to IDLE after `IDLE_CYCLES` consecutive cycles with no strobe.
- Idle counter:
  - Counts cycles since the last accepted strobe and saturates at `IDLE_CYCLES`.
  - It is cleared by every accepted strobe.
- Timeout in CMD, PAYLOAD or STOP:
  - Pulse `frame_error`, discard the partial byte, and go directly to IDLE. WAIT_IDLE is skipped because the line is already idle.
- A strobe and a timeout in the same cycle: the strobe wins, because the counter is cleared.
- `enable` low:
  - Strobes are ignored and the idle counter freezes.
  - Outputs keep their values; the pulse outputs stay at 0.
- Reset values: `cmd`=0x00, `byte_data`=0x00, `byte_index`=0, all pulse outputs 0, `busy`=0, FSM in IDLE, counters at 0.
- Reset in the middle of a frame: asynchronous return to the reset values. The next strobe after reset is treated as bit 7 of a new command.

## Timing

- Latency is 1 cycle, registered. `cmd_valid`, `byte_valid`, `frame_done` and `frame_error` assert in the cycle after the strobe that completes the event.
- `byte_data` and `byte_index` are stable in the same cycle as `byte_valid` and hold until the next completed byte.
- A timeout error fires `IDLE_CYCLES` cycles after the last strobe: the last strobe is at edge N and `frame_error` is high in cycle N+`IDLE_CYCLES`.
- `busy` rises in the cycle after the first strobe. It falls in the cycle the FSM re-enters IDLE.
- Back-to-back strobes on consecutive cycles must be accepted; there is no minimum spacing.

## Structure

- Shared package `n64_pkg` holds:
  - Command constants: `CMD_INFO`=0x00, `CMD_POLL`=0x01, `CMD_READ`=0x02, `CMD_WRITE`=0x03, `CMD_RESET`=0xFF.
  - The FSM state enum.
  - A length-lookup function that maps a command to its byte count.
- One natural sub-module, `n64_bit_shifter`: an 8-bit MSB-first shift register with a bit counter, `load`/`clear` inputs and a `byte_done` output.
- The FSM, idle counter and output registers live in the top level.

## Test plan

- Poll: strobes 0000_0001 then stop bit 1 → `cmd_valid` with `cmd`=0x01, one `byte_valid` (index 0), `frame_done` one cycle after the stop strobe, `busy` low after `IDLE_CYCLES` idle cycles.
- Read: 0x02, 0x80, 0x01, then stop bit 1 → three `byte_valid` pulses (0x02/0, 0x80/1, 0x01/2), then `frame_done`. `frame_error` never asserts.
- Bad stop bit: 0x00 followed by a stop bit of 0 → `cmd_valid` with `cmd`=0x00, then `frame_error`. `frame_done` never asserts.
- Unknown command: 0x55 followed by 12 more strobes → `cmd_valid` and `frame_error` in the same cycle, no further `byte_valid`, return to IDLE once strobes stop for `IDLE_CYCLES` cycles.
- Mid-frame timeout: 0x03, 0xAA, then 4 bits of the next byte, then silence → `frame_error` exactly `IDLE_CYCLES` cycles after the 4th bit. The next strobe starts a new command.
- Reset and enable: assert `reset` low during the payload of a write → all outputs return to 0 immediately. Separately, toggling strobes while `enable`=0 produces no pulses and no state change.
